veggie_physics_engine: RTL and testbench

Parametrised physics and scoring core for the Veggie Samurai playfield. It manages NUM_VEGGIES independent veggies: spawning, gravity and velocity integration, wall reflection, katana hit detection, splitting, fall-off and miss counting. It runs once per video frame, processing one veggie per clock. It exports per-veggie position and state to the sprite and renderer blocks.

---
 rtl/veggie_physics_engine_if.sv | 33 +++
 rtl/veggie_physics_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_veggie_physics_engine.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/veggie_physics_engine_if.sv
// Playfield bus between the video timing/katana/LFSR sources and the physics core.
// Latency: none, wires only.
// Backpressure: none; frame ticks offered while the core is busy are dropped.
interface veggie_physics_engine_if #(
  parameter int NUM_VEGGIES = 4
);
  logic [10:0]               hcount_in;
  logic [9:0]                vcount_in;
  logic [10:0]               katana_x_in;
  logic [9:0]                katana_y_in;
  logic [15:0]               random_in;
  logic                      enable_in;
  logic [11*NUM_VEGGIES-1:0] veggie_x_out;
  logic [10*NUM_VEGGIES-1:0] veggie_y_out;
  logic [NUM_VEGGIES-1:0]    active_out;
  logic [NUM_VEGGIES-1:0]    split_out;
  logic                      split_pulse_out;
  logic [15:0]               score_out;
  logic [7:0]                misses_out;
  logic                      busy_out;

  modport master (
    output hcount_in, vcount_in, katana_x_in, katana_y_in, random_in, enable_in,
    input  veggie_x_out, veggie_y_out, active_out, split_out, split_pulse_out,
           score_out, misses_out, busy_out
  );

  modport slave (
    input  hcount_in, vcount_in, katana_x_in, katana_y_in, random_in, enable_in,
    output veggie_x_out, veggie_y_out, active_out, split_out, split_pulse_out,
           score_out, misses_out, busy_out
  );
endinterface

// File: rtl/veggie_physics_engine.sv
// Veggie physics/scoring core: spawn, gravity, wall bounce, katana hits, fall-off, once per frame.
// Latency: NUM_VEGGIES cycles per accepted frame tick, one slot per clock; outputs follow one cycle later.
// Backpressure: ticks arriving while paused or mid-sweep are silently dropped.
module veggie_physics_engine #(
  parameter int NUM_VEGGIES = 4,
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 768,
  parameter int VEG_W       = 64,
  parameter int VEG_H       = 64,
  parameter int GRAVITY     = 1,
  parameter int LAUNCH_VY   = 24,
  parameter int SPAWN_GAP   = 60,
  parameter int SPAWN_X_MIN = 128
) (
  input logic clk_in,
  input logic rst_in,
  veggie_physics_engine_if.slave bus
);

  localparam int IDXW = (NUM_VEGGIES > 1) ? $clog2(NUM_VEGGIES) : 1;

  // Geometry constants pre-sized so every comparison stays in one signed width.
  localparam logic signed [13:0] BOX_W      = 14'(VEG_W);
  localparam logic signed [13:0] BOX_H      = 14'(VEG_H);
  localparam logic signed [13:0] X_MAX      = 14'(SCREEN_W - VEG_W);
  localparam logic signed [13:0] Y_LIM      = 14'(SCREEN_H);
  localparam logic signed [9:0]  GRAV       = 10'(GRAVITY);
  localparam logic signed [9:0]  VY_MAX     = 10'sd127;
  localparam logic [10:0]        X_BASE     = 11'(SPAWN_X_MIN);
  localparam logic signed [11:0] Y_SPAWN    = 12'(SCREEN_H - VEG_H);
  localparam logic signed [7:0]  VY_LAUNCH  = 8'(-LAUNCH_VY);
  localparam logic [15:0]        GAP_RELOAD = 16'(SPAWN_GAP);
  localparam logic [IDXW-1:0]    LAST_IDX   = IDXW'(NUM_VEGGIES - 1);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_FLYING, SLOT_SPLIT} slot_t;
  typedef enum logic {CTL_WAIT, CTL_SWEEP} ctl_t;

  ctl_t            state, state_nxt;
  logic [IDXW-1:0] idx, idx_nxt;
  logic [15:0]     timer, timer_nxt;
  logic            spawn_vld, spawn_vld_nxt;
  logic [IDXW-1:0] spawn_idx, spawn_idx_nxt;
  logic            frame_tick;
  logic            free_vld;
  logic [IDXW-1:0] free_idx;
  logic            sweeping;
  logic            do_spawn;

  slot_t             slot_st [NUM_VEGGIES];
  logic [10:0]       pos_x   [NUM_VEGGIES];
  logic signed [11:0] pos_y  [NUM_VEGGIES];
  logic signed [3:0] vel_x   [NUM_VEGGIES];
  logic signed [7:0] vel_y   [NUM_VEGGIES];

  slot_t             cur_st, upd_st;
  logic [10:0]       cur_x, upd_x;
  logic signed [11:0] cur_y, upd_y;
  logic signed [3:0] cur_vx, upd_vx;
  logic signed [7:0] cur_vy, upd_vy;
  logic              hit, miss, in_box;
  logic signed [13:0] sx, sy, skx, sky, nx, ny;
  logic signed [9:0] vy_sum;

  logic             split_pulse;
  logic [15:0]      score;
  logic [7:0]       misses;

  assign sweeping = (state == CTL_SWEEP);

  // Frame tick is registered so the video counters never feed control logic directly.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) frame_tick <= 1'b0;
    else        frame_tick <= (bus.hcount_in == 11'd1024) && (bus.vcount_in == 10'd768);
  end

  // Lowest-indexed idle slot is the spawn candidate for this frame.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = NUM_VEGGIES - 1; i >= 0; i--) begin
      if (slot_st[i] == SLOT_IDLE) begin
        free_vld = 1'b1;
        free_idx = IDXW'(i);
      end
    end
  end

  // Controller state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= CTL_WAIT;
      idx       <= '0;
      timer     <= GAP_RELOAD;
      spawn_vld <= 1'b0;
      spawn_idx <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      timer     <= timer_nxt;
      spawn_vld <= spawn_vld_nxt;
      spawn_idx <= spawn_idx_nxt;
    end
  end

  // Controller next state: accept a tick only when idle, run the spawn timer, walk the slots.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    timer_nxt     = timer;
    spawn_vld_nxt = spawn_vld;
    spawn_idx_nxt = spawn_idx;
    case (state)
      CTL_WAIT: begin
        if (frame_tick && bus.enable_in) begin
          state_nxt = CTL_SWEEP;
          idx_nxt   = '0;
          if (timer != 16'd0) begin
            timer_nxt     = timer - 16'd1;
            spawn_vld_nxt = 1'b0;
          end else begin
            // No free slot leaves the timer at zero so the spawn retries next frame.
            spawn_vld_nxt = free_vld;
            spawn_idx_nxt = free_idx;
          end
        end
      end
      CTL_SWEEP: begin
        if (do_spawn) timer_nxt = GAP_RELOAD;
        if (idx == LAST_IDX) begin
          state_nxt     = CTL_WAIT;
          idx_nxt       = '0;
          spawn_vld_nxt = 1'b0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = CTL_WAIT;
    endcase
  end

  // Fetch the slot under the sweep pointer.
  always_comb begin
    cur_st = slot_st[idx];
    cur_x  = pos_x[idx];
    cur_y  = pos_y[idx];
    cur_vx = vel_x[idx];
    cur_vy = vel_y[idx];
  end

  assign do_spawn = sweeping && spawn_vld && (idx == spawn_idx) && (cur_st == SLOT_IDLE);

  // Per-slot physics from pre-update values: spawn, hit, or integrate/bounce/fall.
  always_comb begin
    upd_st = cur_st;
    upd_x  = cur_x;
    upd_y  = cur_y;
    upd_vx = cur_vx;
    upd_vy = cur_vy;
    hit    = 1'b0;
    miss   = 1'b0;
    sx     = $signed({3'b000, cur_x});
    sy     = $signed({{2{cur_y[11]}}, cur_y});
    skx    = $signed({3'b000, bus.katana_x_in});
    sky    = $signed({4'b0000, bus.katana_y_in});
    nx     = sx + $signed({{10{cur_vx[3]}}, cur_vx});
    ny     = sy + $signed({{6{cur_vy[7]}}, cur_vy});
    vy_sum = $signed({{2{cur_vy[7]}}, cur_vy}) + GRAV;
    in_box = (skx >= sx) && (skx < sx + BOX_W) && (sky >= sy) && (sky < sy + BOX_H);
    if (cur_st == SLOT_IDLE) begin
      if (do_spawn) begin
        upd_st = SLOT_FLYING;
        upd_x  = X_BASE + {2'b00, bus.random_in[8:0]};
        upd_vx = $signed({bus.random_in[11], bus.random_in[11:9]});
        upd_y  = Y_SPAWN;
        upd_vy = VY_LAUNCH;
      end
    end else if ((cur_st == SLOT_FLYING) && in_box) begin
      upd_st = SLOT_SPLIT;
      hit    = 1'b1;
    end else begin
      upd_y  = ny[11:0];
      upd_vy = (vy_sum > VY_MAX) ? 8'sd127 : vy_sum[7:0];
      if (nx[13] || (nx > X_MAX)) upd_vx = -cur_vx;
      else                        upd_x  = nx[10:0];
      if (ny >= Y_LIM) begin
        upd_st = SLOT_IDLE;
        miss   = (cur_st == SLOT_FLYING);
      end
    end
  end

  // Slot storage: only the slot under the pointer is written during a sweep.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_VEGGIES; i++) begin
        slot_st[i] <= SLOT_IDLE;
        pos_x[i]   <= '0;
        pos_y[i]   <= '0;
        vel_x[i]   <= '0;
        vel_y[i]   <= '0;
      end
    end else if (sweeping) begin
      slot_st[idx] <= upd_st;
      pos_x[idx]   <= upd_x;
      pos_y[idx]   <= upd_y;
      vel_x[idx]   <= upd_vx;
      vel_y[idx]   <= upd_vy;
    end
  end

  // Score, misses and the per-split pulse; counters saturate rather than wrap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      split_pulse <= 1'b0;
      score       <= '0;
      misses      <= '0;
    end else begin
      split_pulse <= sweeping && hit;
      if (sweeping && hit && (score != 16'hFFFF)) score <= score + 16'd1;
      if (sweeping && miss && (misses != 8'hFF)) misses <= misses + 8'd1;
    end
  end

  // Export packed per-slot views; y above the screen top is shown as row 0.
  always_comb begin
    bus.veggie_x_out = '0;
    bus.veggie_y_out = '0;
    bus.active_out   = '0;
    bus.split_out    = '0;
    for (int i = 0; i < NUM_VEGGIES; i++) begin
      bus.veggie_x_out[11*i +: 11] = pos_x[i];
      bus.veggie_y_out[10*i +: 10] = pos_y[i][11] ? 10'd0 : pos_y[i][9:0];
      bus.active_out[i]            = (slot_st[i] != SLOT_IDLE);
      bus.split_out[i]             = (slot_st[i] == SLOT_SPLIT);
    end
  end

  assign bus.split_pulse_out = split_pulse;
  assign bus.score_out       = score;
  assign bus.misses_out      = misses;
  assign bus.busy_out        = sweeping;

endmodule

// File: tb/tb_veggie_physics_engine.sv
// Bench for veggie_physics_engine: directed frames plus random play against a frame-level model.
// Latency: expected state is queued per frame and compared when each sweep ends.
// Backpressure: every wait on the DUT is cycle-bounded.
module tb_veggie_physics_engine;
  localparam int N   = 4;
  localparam int GAP = 10;
  localparam int OFF_X = 2000;
  localparam int OFF_Y = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  veggie_physics_engine_if #(.NUM_VEGGIES(N)) bus ();
  veggie_physics_engine #(.NUM_VEGGIES(N), .SPAWN_GAP(GAP)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [11*N-1:0] x;
    logic [10*N-1:0] y;
    logic [N-1:0]    act;
    logic [N-1:0]    spl;
    logic [15:0]     score;
    logic [7:0]      miss;
    logic [7:0]      pulses;
  } exp_t;

  exp_t expq[$];

  // Reference model: whole-frame update on plain integers (0 idle, 1 flying, 2 split).
  int mx[N], my[N], mvx[N], mvy[N], mst[N];
  int mtimer, mscore, mmiss;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; mst[i] = 0;
    end
    mtimer = GAP; mscore = 0; mmiss = 0;
  endtask

  task automatic model_frame(input int kx, input int ky, input int rnd, output int hits);
    int sp;
    hits = 0;
    sp = -1;
    if (mtimer > 0) mtimer--;
    else for (int i = N - 1; i >= 0; i--) if (mst[i] == 0) sp = i;
    for (int i = 0; i < N; i++) begin
      if (mst[i] == 0) begin
        if (i == sp) begin
          mx[i]  = 128 + (rnd & 511);
          mvx[i] = (rnd >> 9) & 7;
          if (mvx[i] > 3) mvx[i] -= 8;
          my[i]  = 768 - 64;
          mvy[i] = -24;
          mst[i] = 1;
          mtimer = GAP;
        end
      end else if (mst[i] == 1 && kx >= mx[i] && kx < mx[i] + 64 && ky >= my[i] && ky < my[i] + 64) begin
        mst[i] = 2;
        hits++;
        if (mscore < 65535) mscore++;
      end else begin
        my[i] += mvy[i];
        mvy[i] = (mvy[i] + 1 > 127) ? 127 : mvy[i] + 1;
        if (mx[i] + mvx[i] < 0 || mx[i] + mvx[i] > 1024 - 64) mvx[i] = -mvx[i];
        else mx[i] += mvx[i];
        if (my[i] >= 768) begin
          if (mst[i] == 1 && mmiss < 255) mmiss++;
          mst[i] = 0;
        end
      end
    end
  endtask

  function automatic exp_t snapshot(input int hits);
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.x[11*i +: 11] = 11'(mx[i]);
      e.y[10*i +: 10] = (my[i] < 0) ? 10'd0 : 10'(my[i]);
      e.act[i] = (mst[i] != 0);
      e.spl[i] = (mst[i] == 2);
    end
    e.score  = 16'(mscore);
    e.miss   = 8'(mmiss);
    e.pulses = 8'(hits);
    return e;
  endfunction

  // Monitor: at the first idle cycle after each sweep, compare against the queued frame.
  initial begin
    bit prev_busy;
    int pcnt, bcnt;
    exp_t e;
    prev_busy = 1'b0; pcnt = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0; pcnt = 0; bcnt = 0;
      end else begin
        if (bus.split_pulse_out) pcnt++;
        if (bus.busy_out) bcnt++;
        else if (prev_busy) begin
          check("sweep_queue", 64'(expq.size() != 0), 64'd1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            check("sweep_x", 64'(bus.veggie_x_out), 64'(e.x));
            check("sweep_y", 64'(bus.veggie_y_out), 64'(e.y));
            check("sweep_active", 64'(bus.active_out), 64'(e.act));
            check("sweep_split", 64'(bus.split_out), 64'(e.spl));
            check("sweep_score", 64'(bus.score_out), 64'(e.score));
            check("sweep_misses", 64'(bus.misses_out), 64'(e.miss));
            check("sweep_pulses", 64'(pcnt), 64'(e.pulses));
            check("sweep_cycles", 64'(bcnt), 64'(N));
          end
          pcnt = 0; bcnt = 0;
        end
        prev_busy = bus.busy_out;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_x"}, 64'(bus.veggie_x_out), 64'd0);
    check({tag, "_y"}, 64'(bus.veggie_y_out), 64'd0);
    check({tag, "_active"}, 64'(bus.active_out), 64'd0);
    check({tag, "_split"}, 64'(bus.split_out), 64'd0);
    check({tag, "_pulse"}, 64'(bus.split_pulse_out), 64'd0);
    check({tag, "_score"}, 64'(bus.score_out), 64'd0);
    check({tag, "_misses"}, 64'(bus.misses_out), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy_out), 64'd0);
  endtask

  // One video frame: present the tick (optionally twice), then wait out the sweep.
  task automatic frame(input bit en, input int kx, input int ky, input int rnd, input bit dbl);
    int hits;
    int cyc;
    bit seen;
    exp_t e;
    @(posedge clk); #1;
    bus.enable_in   = en;
    bus.katana_x_in = 11'(kx);
    bus.katana_y_in = 10'(ky);
    bus.random_in   = 16'(rnd);
    bus.hcount_in   = 11'd1024;
    bus.vcount_in   = 10'd768;
    if (en) begin
      model_frame(kx, ky, rnd, hits);
      expq.push_back(snapshot(hits));
    end
    @(posedge clk); #1;
    if (dbl) begin @(posedge clk); #1; end
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd0;
    seen = 1'b0;
    cyc = 0;
    if (en) begin
      while (cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (bus.busy_out) seen = 1'b1;
        else if (seen) break;
      end
      check("sweep_done", 64'(seen & ~bus.busy_out), 64'd1);
    end else begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.busy_out) seen = 1'b1;
      end
      e = snapshot(0);
      check("pause_busy", 64'(seen), 64'd0);
      check("pause_x", 64'(bus.veggie_x_out), 64'(e.x));
      check("pause_y", 64'(bus.veggie_y_out), 64'(e.y));
      check("pause_active", 64'(bus.active_out), 64'(e.act));
    end
  endtask

  // Start a sweep, then hit reset between clock edges and expect everything cleared at once.
  task automatic reset_mid_sweep();
    @(posedge clk); #1;
    bus.enable_in = 1'b1;
    bus.hcount_in = 11'd1024;
    bus.vcount_in = 10'd768;
    @(posedge clk); #1;
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd0;
    @(posedge clk); #2;
    check("midsweep_busy_before", 64'(bus.busy_out), 64'd1);
    rst = 1'b1;
    #1;
    check_zero("midsweep_rst");
    expq.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int kx, ky, s;
    bus.hcount_in = 11'd0; bus.vcount_in = 10'd0;
    bus.katana_x_in = 11'd0; bus.katana_y_in = 10'd0;
    bus.random_in = 16'd0; bus.enable_in = 1'b0;
    model_reset();
    #23;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Spawn after the timer runs out, then follow the ballistic arc to a miss.
    for (int f = 0; f < GAP + 1; f++) frame(1'b1, OFF_X, OFF_Y, 0, 1'b0);
    check("spawn_active", 64'(bus.active_out), 64'h1);
    check("spawn_x", 64'(bus.veggie_x_out[10:0]), 64'd128);
    check("spawn_y", 64'(bus.veggie_y_out[9:0]), 64'd704);
    frame(1'b1, OFF_X, OFF_Y, 0, 1'b0);
    check("traj_y1", 64'(bus.veggie_y_out[9:0]), 64'd680);
    for (int f = 0; f < 48; f++) frame(1'b1, OFF_X, OFF_Y, 0, 1'b0);
    check("traj_y49", 64'(bus.veggie_y_out[9:0]), 64'd704);
    frame(1'b1, OFF_X, OFF_Y, 0, 1'b0);
    check("traj_y50", 64'(bus.veggie_y_out[9:0]), 64'd729);
    frame(1'b1, OFF_X, OFF_Y, 0, 1'b0);
    check("traj_y51", 64'(bus.veggie_y_out[9:0]), 64'd755);
    frame(1'b1, OFF_X, OFF_Y, 0, 1'b0);
    check("fall_misses", 64'(bus.misses_out), 64'd1);
    check("fall_active_full_retry", 64'(bus.active_out), 64'hE);
    frame(1'b1, OFF_X, OFF_Y, 0, 1'b0);
    check("respawn_active", 64'(bus.active_out), 64'hF);
    check("respawn_y", 64'(bus.veggie_y_out[9:0]), 64'd704);

    // Katana hit right after spawn; holding the katana must not score again.
    reset_mid_sweep();
    for (int f = 0; f < GAP + 1; f++) frame(1'b1, OFF_X, OFF_Y, 0, 1'b0);
    frame(1'b1, 150, 720, 0, 1'b0);
    check("hit_score", 64'(bus.score_out), 64'd1);
    check("hit_split", 64'(bus.split_out), 64'h1);
    for (int f = 0; f < 3; f++) frame(1'b1, 150, 720, 0, 1'b0);
    check("hit_held_score", 64'(bus.score_out), 64'd1);

    // Left-wall bounce: vx=-4 from x=128 reaches 0, holds there once, then comes back.
    reset_mid_sweep();
    for (int f = 0; f < GAP + 1; f++) frame(1'b1, OFF_X, OFF_Y, 16'h0800, 1'b0);
    for (int f = 0; f < 32; f++) frame(1'b1, OFF_X, OFF_Y, 16'h0800, 1'b0);
    check("wall_x_reach", 64'(bus.veggie_x_out[10:0]), 64'd0);
    frame(1'b1, OFF_X, OFF_Y, 16'h0800, 1'b0);
    check("wall_x_hold", 64'(bus.veggie_x_out[10:0]), 64'd0);
    frame(1'b1, OFF_X, OFF_Y, 16'h0800, 1'b0);
    check("wall_x_back", 64'(bus.veggie_x_out[10:0]), 64'd4);

    // Random play: pauses, doubled ticks, katana aimed near live veggies.
    reset_mid_sweep();
    for (int f = 0; f < 260; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        kx = OFF_X; ky = OFF_Y;
      end else begin
        s  = int'($urandom_range(0, N - 1));
        kx = mx[s] + int'($urandom_range(0, 67)) - 2;
        ky = my[s] + int'($urandom_range(0, 67)) - 2;
        if (kx < 0) kx = 0;
        if (ky < 0) ky = 0;
        if (ky > 1023) ky = 1023;
      end
      frame($urandom_range(0, 9) != 0, kx, ky, int'($urandom_range(0, 65535)),
            $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
